// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage : data-memory stage of the 5-stage MIPS datapath.
//
// Holds a word-organised, little-endian data RAM of 2**ADDR_WIDTH 32-bit
// words. Stores are synchronous and loads are combinational, so a value
// written on a clock edge appears on MEM_DataOut in the same cycle, after
// the edge. lb/sb (opcodes 6'b000011 / 6'b000111) access a single byte.
// Every other opcode is a full-word access that ignores the low two
// address bits. Byte loads are zero-extended.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset; blocks writes and
//                      forces MEM_DataOut to zero. RAM contents are kept.
//   opcode        in   [5:0]  instruction opcode (selects byte/word size)
//   Mem_WrEn      in   RAM write enable
//   ALU_MEM_Addr  in   [31:0] byte address; bits above ADDR_WIDTH+1 ignored
//   MEM_Dataln    in   [31:0] store data
//   MEM_DataOut   out  [31:0] load data
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic                  Mem_WrEn,
    input  logic [31:0]           ALU_MEM_Addr,
    input  logic [DATA_WIDTH-1:0] MEM_Dataln,
    output logic [DATA_WIDTH-1:0] MEM_DataOut
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [5:0] OP_LB = 6'b000011;
    localparam logic [5:0] OP_SB = 6'b000111;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  byte_acc;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;

    // Zero power-up contents via the declaration initialiser (maps to an
    // all-zero init image on FPGA block RAM); reset never touches the array.
    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1] = '{default: '0};

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALU_MEM_Addr[31:ADDR_WIDTH+2];

    assign word_idx = ALU_MEM_Addr[ADDR_WIDTH+1:2];
    assign lane     = ALU_MEM_Addr[1:0];
    assign byte_acc = (opcode == OP_LB) || (opcode == OP_SB);

    // Byte stores replicate the low byte into every lane and let the lane
    // enable pick one; this keeps the write port a plain byte-enable RAM.
    always_comb begin
        byte_en = 4'b1111;
        wr_data = MEM_Dataln;
        if (byte_acc) begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{MEM_Dataln[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && Mem_WrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = ram[word_idx];

    always_comb begin
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        if (rst) begin
            MEM_DataOut = '0;
        end else if (byte_acc) begin
            MEM_DataOut = {24'b0, rd_byte};
        end else begin
            MEM_DataOut = rd_word;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage : self-checking bench for mem_stage.
// Directed vector table, a hand-written read-before/after-edge sequence,
// and a randomized phase checked against a byte-array memory model.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        Mem_WrEn;
    logic [31:0] ALU_MEM_Addr;
    logic [31:0] MEM_Dataln;
    logic [31:0] MEM_DataOut;

    int errors = 0;
    int checks = 0;

    mem_stage #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .Mem_WrEn    (Mem_WrEn),
        .ALU_MEM_Addr(ALU_MEM_Addr),
        .MEM_Dataln  (MEM_Dataln),
        .MEM_DataOut (MEM_DataOut)
    );

    always #5 clk = ~clk;

    // Reference: 4 KiB of bytes, little-endian.
    logic [7:0] mb [0:4095];

    function automatic logic is_byte(input logic [5:0] op);
        return (op == 6'd3) || (op == 6'd7);
    endfunction

    function automatic logic [31:0] model_read(input logic r, input logic [5:0] op,
                                               input logic [31:0] a);
        int base;
        if (r) return 32'h0;
        if (is_byte(op)) return {24'h0, mb[a % 4096]};
        base = (a % 4096) / 4 * 4;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic model_write(input logic r, input logic [5:0] op, input logic we,
                               input logic [31:0] a, input logic [31:0] d);
        int base;
        if (r || !we) return;
        if (is_byte(op)) begin
            mb[a % 4096] = d[7:0];
        end else begin
            base = (a % 4096) / 4 * 4;
            mb[base]   = d[7:0];
            mb[base+1] = d[15:8];
            mb[base+2] = d[23:16];
            mb[base+3] = d[31:24];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive at negedge, clock, update model, then settle past the edge.
    task automatic drive(input logic r, input logic [5:0] op, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; opcode = op; Mem_WrEn = we; ALU_MEM_Addr = a; MEM_Dataln = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_write(rst, opcode, Mem_WrEn, ALU_MEM_Addr, MEM_Dataln);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        r;
        logic [5:0]  ops [6];

        for (int i = 0; i < 4096; i++) mb[i] = 8'h0;
        rst = 1'b1; opcode = 6'h0; Mem_WrEn = 1'b0; ALU_MEM_Addr = '0; MEM_Dataln = '0;

        // {rst, opcode, we, addr, data, expected MEM_DataOut after the edge}
        tbl[0]  = '{1'b1, 6'h00, 1'b0, 32'h0,    32'h0,        32'h0};
        tbl[1]  = '{1'b0, 6'h00, 1'b1, 32'h2,    32'h2AA,      32'h2AA};
        tbl[2]  = '{1'b0, 6'h00, 1'b0, 32'h2,    32'h0,        32'h2AA};
        tbl[3]  = '{1'b0, 6'h00, 1'b0, 32'h0,    32'h0,        32'h2AA};
        tbl[4]  = '{1'b0, 6'h07, 1'b1, 32'hC,    32'h0003FFFF, 32'hFF};
        tbl[5]  = '{1'b0, 6'h07, 1'b0, 32'hC,    32'h0,        32'hFF};
        tbl[6]  = '{1'b0, 6'h0F, 1'b0, 32'hC,    32'h0,        32'hFF};
        tbl[7]  = '{1'b0, 6'h1F, 1'b1, 32'h20,   32'h11223344, 32'h11223344};
        tbl[8]  = '{1'b0, 6'h07, 1'b1, 32'h22,   32'hAA,       32'hAA};
        tbl[9]  = '{1'b0, 6'h0F, 1'b0, 32'h20,   32'h0,        32'h11AA3344};
        tbl[10] = '{1'b0, 6'h03, 1'b0, 32'h23,   32'h0,        32'h11};
        tbl[11] = '{1'b0, 6'h03, 1'b0, 32'h22,   32'h0,        32'hAA};
        tbl[12] = '{1'b0, 6'h1F, 1'b0, 32'h40,   32'hDEADBEEF, 32'h0};
        tbl[13] = '{1'b0, 6'h1F, 1'b0, 32'h40,   32'hDEADBEEF, 32'h0};
        tbl[14] = '{1'b0, 6'h0F, 1'b0, 32'h40,   32'h0,        32'h0};
        tbl[15] = '{1'b0, 6'h1F, 1'b1, 32'h80,   32'hCAFEF00D, 32'hCAFEF00D};
        tbl[16] = '{1'b1, 6'h1F, 1'b1, 32'h80,   32'h12345678, 32'h0};
        tbl[17] = '{1'b1, 6'h1F, 1'b1, 32'h80,   32'h12345678, 32'h0};
        tbl[18] = '{1'b0, 6'h0F, 1'b0, 32'h80,   32'h0,        32'hCAFEF00D};
        tbl[19] = '{1'b0, 6'h1F, 1'b1, 32'h1004, 32'h55AA55AA, 32'h55AA55AA};
        tbl[20] = '{1'b0, 6'h0F, 1'b0, 32'h4,    32'h0,        32'h55AA55AA};

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].we, tbl[i].a, tbl[i].d);
            tick();
            check($sformatf("vec%0d", i), MEM_DataOut, tbl[i].exp);
        end

        // Read is combinational: old value before the write edge, new after.
        drive(1'b0, 6'h1F, 1'b1, 32'h100, 32'hA5A5_1234);
        #1 check("pre_edge_old", MEM_DataOut, 32'h0);
        tick();
        check("post_edge_new", MEM_DataOut, 32'hA5A5_1234);
        // Address/opcode change without a clock edge.
        @(negedge clk);
        Mem_WrEn = 1'b0; opcode = 6'h03; ALU_MEM_Addr = 32'h101;
        #1 check("comb_lb_lane1", MEM_DataOut, 32'h12);
        ALU_MEM_Addr = 32'h103;
        #1 check("comb_lb_lane3", MEM_DataOut, 32'hA5);
        rst = 1'b1;
        #1 check("comb_rst_zero", MEM_DataOut, 32'h0);
        tick();
        // Byte store in reset is blocked as well.
        drive(1'b1, 6'h07, 1'b1, 32'h102, 32'h77);
        tick();
        drive(1'b0, 6'h0F, 1'b0, 32'h100, 32'h0);
        tick();
        check("rst_blocks_sb", MEM_DataOut, 32'hA5A5_1234);

        // Randomized phase against the byte-array model.
        ops = '{6'h00, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h2A};
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            we = 1'($urandom);
            r  = ($urandom_range(0, 15) == 0);
            a  = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0,
                  12'($urandom_range(0, 63))};
            d  = $urandom;
            drive(r, op, we, a, d);
            #1 check($sformatf("rnd%0d_pre", i), MEM_DataOut, model_read(r, op, a));
            tick();
            check($sformatf("rnd%0d_post", i), MEM_DataOut, model_read(r, op, a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
